// File: rtl/vga_write_arbiter_pkg.sv
// Shared VGA constants, arbiter state encoding and the pixel payload type.
package vga_pkg;

   localparam int unsigned VGA_XW   = 9;
   localparam int unsigned VGA_YW   = 8;
   localparam int unsigned VGA_CW   = 3;
   localparam int unsigned VGA_XMAX = 320;
   localparam int unsigned VGA_YMAX = 240;
   localparam int unsigned OWNER_W  = 3;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic [VGA_XW-1:0] x;
      logic [VGA_YW-1:0] y;
      logic [VGA_CW-1:0] colour;
   } pixel_t;

endpackage

// File: rtl/vga_write_arbiter_if.sv
// Pixel-producer bundle: NREQ packed request lanes plus the one-hot accept.
interface vga_write_arbiter_if #(
   parameter int unsigned NREQ = 3
);

   logic [NREQ-1:0]                   req_valid;
   logic [NREQ-1:0]                   req_last;
   logic [NREQ*vga_pkg::VGA_XW-1:0]   req_x;
   logic [NREQ*vga_pkg::VGA_YW-1:0]   req_y;
   logic [NREQ*vga_pkg::VGA_CW-1:0]   req_colour;
   logic [NREQ-1:0]                   req_ready;

   modport master (output req_valid, req_last, req_x, req_y, req_colour, input req_ready);
   modport slave  (input req_valid, req_last, req_x, req_y, req_colour, output req_ready);

endinterface

// File: rtl/vga_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or after ptr, wrapping.
module rr_pick
   import vga_pkg::*;
#(
   parameter int unsigned NREQ = 3
) (
   input  logic [NREQ-1:0]    valid_i,
   input  logic [OWNER_W-1:0] ptr_i,
   output logic [OWNER_W-1:0] idx_o,
   output logic               any_o
);

   logic [OWNER_W-1:0] hi_idx;
   logic [OWNER_W-1:0] lo_idx;
   logic               hi_any;

   // Lowest valid index overall is the wrap-around fallback.
   always_comb begin
      hi_idx = '0;
      lo_idx = '0;
      hi_any = 1'b0;
      any_o  = 1'b0;
      for (int i = int'(NREQ) - 1; i >= 0; i--) begin
         if (valid_i[i]) begin
            any_o  = 1'b1;
            lo_idx = OWNER_W'(i);
            if (OWNER_W'(i) >= ptr_i) begin
               hi_any = 1'b1;
               hi_idx = OWNER_W'(i);
            end
         end
      end
      idx_o = hi_any ? hi_idx : lo_idx;
   end

endmodule

// File: rtl/vga_write_arbiter.sv
// Round-robin, job-locking arbiter sharing the vga_adapter pixel-write port.
module vga_write_arbiter
   import vga_pkg::*;
#(
   parameter int unsigned NREQ      = 3,
   parameter int unsigned MAX_BURST = 256,
   parameter int unsigned XMAX      = VGA_XMAX,
   parameter int unsigned YMAX      = VGA_YMAX
) (
   input  logic                clock,
   input  logic                resetn,
   vga_write_arbiter_if.slave  req,
   output logic [VGA_XW-1:0]   vga_x,
   output logic [VGA_YW-1:0]   vga_y,
   output logic [VGA_CW-1:0]   vga_colour,
   output logic                vga_plot,
   output logic                busy,
   output logic [OWNER_W-1:0]  owner
);

   localparam int unsigned BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

   arb_state_e         state_q, state_d;
   logic [OWNER_W-1:0] owner_q, owner_d;
   logic [OWNER_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [BW-1:0]      burst_q, burst_d;
   pixel_t             pix_q, pix_d;
   logic               plot_q, plot_d;

   logic [OWNER_W-1:0] pick_idx;
   logic               pick_any;
   pixel_t             sel_pix;
   logic               sel_valid;
   logic               sel_last;
   logic [NREQ-1:0]    ready_c;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .valid_i (req.req_valid),
      .ptr_i   (rr_ptr_q),
      .idx_o   (pick_idx),
      .any_o   (pick_any)
   );

   // Route the current owner's lane; non-owners are never looked at.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_pix   = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (owner_q == OWNER_W'(i)) begin
            sel_valid      = req.req_valid[i];
            sel_last       = req.req_last[i];
            sel_pix.x      = req.req_x[i*VGA_XW +: VGA_XW];
            sel_pix.y      = req.req_y[i*VGA_YW +: VGA_YW];
            sel_pix.colour = req.req_colour[i*VGA_CW +: VGA_CW];
         end
      end
   end

   always_comb begin
      ready_c = '0;
      if (state_q == OWN) begin
         for (int unsigned i = 0; i < NREQ; i++) begin
            ready_c[i] = (owner_q == OWNER_W'(i));
         end
      end
   end

   assign req.req_ready = ready_c;

   // Next state: arbitrate in IDLE, stream the owner's pixels in OWN.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      burst_d  = burst_q;
      pix_d    = pix_q;
      plot_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d = OWN;
               owner_d = pick_idx;
            end
         end
         OWN: begin
            if (sel_valid) begin
               pix_d   = sel_pix;
               plot_d  = (32'(sel_pix.x) < XMAX) && (32'(sel_pix.y) < YMAX);
               burst_d = burst_q + BW'(1);
               if (sel_last || (burst_q == BW'(MAX_BURST - 1))) begin
                  state_d  = IDLE;
                  burst_d  = '0;
                  rr_ptr_d = (owner_q == OWNER_W'(NREQ - 1)) ? '0 : owner_q + OWNER_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         burst_q  <= '0;
         pix_q    <= '0;
         plot_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         burst_q  <= burst_d;
         pix_q    <= pix_d;
         plot_q   <= plot_d;
      end
   end

   assign vga_x      = pix_q.x;
   assign vga_y      = pix_q.y;
   assign vga_colour = pix_q.colour;
   assign vga_plot   = plot_q;
   assign busy       = (state_q == OWN);
   assign owner      = owner_q;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Self-checking bench: randomized and directed producers against a transaction-level arbiter model.
module tb_vga_write_arbiter;
   import vga_pkg::*;

   localparam int NREQ = 3;
   localparam int MAXB = 4;

   logic       clock  = 1'b0;
   logic       resetn = 1'b0;
   logic [8:0] vga_x;
   logic [7:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;
   logic       busy;
   logic [2:0] owner;

   always #5 clock = ~clock;

   vga_write_arbiter_if #(.NREQ(NREQ)) bus ();

   vga_write_arbiter #(.NREQ(NREQ), .MAX_BURST(MAXB), .XMAX(320), .YMAX(240)) dut (
      .clock      (clock),
      .resetn     (resetn),
      .req        (bus),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .vga_plot   (vga_plot),
      .busy       (busy),
      .owner      (owner)
   );

   typedef struct { int x; int y; int c; bit last; int gap; } ent_t;
   typedef struct { int x; int y; int c; int cyc; } plot_t;

   ent_t  q[NREQ][$];
   int    checks = 0;
   int    failures = 0;
   int    cyc = 0;
   bit    cmp_en = 1'b0;

   // Model state: who holds the port, where the pointer is, what must appear next cycle.
   bit    m_own = 1'b0;
   int    m_owner = 0;
   int    m_ptr = 0;
   int    m_cnt = 0;
   bit    e_plot = 1'b0;
   int    e_x = 0, e_y = 0, e_c = 0;
   int    xfer_count = 0;
   int    grant_log[$];
   plot_t plot_log[$];

   logic [NREQ-1:0]   drv_v, drv_l;
   logic [NREQ*9-1:0] drv_x;
   logic [NREQ*8-1:0] drv_y;
   logic [NREQ*3-1:0] drv_c;

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int glog(int k);
      return (k < grant_log.size()) ? grant_log[k] : -1;
   endfunction

   function automatic bit all_empty();
      for (int i = 0; i < NREQ; i++) if (q[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   // Producers: present queue heads, honouring per-entry idle gaps.
   always @(negedge clock) begin
      ent_t h;
      for (int i = 0; i < NREQ; i++) begin
         drv_v[i] = 1'b0;
         drv_l[i] = 1'b0;
         if (q[i].size() > 0) begin
            h = q[i][0];
            if (h.gap > 0) begin
               h.gap = h.gap - 1;
               q[i][0] = h;
            end else begin
               drv_v[i]        = 1'b1;
               drv_l[i]        = h.last;
               drv_x[i*9 +: 9] = 9'(h.x);
               drv_y[i*8 +: 8] = 8'(h.y);
               drv_c[i*3 +: 3] = 3'(h.c);
            end
         end
      end
      bus.req_valid  = drv_v;
      bus.req_last   = drv_l;
      bus.req_x      = drv_x;
      bus.req_y      = drv_y;
      bus.req_colour = drv_c;
   end

   // Arbiter model, stepped once per clock from the values presented before the edge.
   always @(posedge clock) begin
      cyc++;
      if (!resetn) begin
         m_own = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0; e_plot = 1'b0;
      end else begin
         e_plot = 1'b0;
         if (!m_own) begin
            if (bus.req_valid != '0) begin
               for (int k = NREQ - 1; k >= 0; k--)
                  if (bus.req_valid[(m_ptr + k) % NREQ]) m_owner = (m_ptr + k) % NREQ;
               m_own = 1'b1;
               grant_log.push_back(m_owner);
            end
         end else if (bus.req_valid[m_owner]) begin
            e_x    = int'(bus.req_x[m_owner*9 +: 9]);
            e_y    = int'(bus.req_y[m_owner*8 +: 8]);
            e_c    = int'(bus.req_colour[m_owner*3 +: 3]);
            e_plot = (e_x < 320) && (e_y < 240);
            m_cnt++;
            xfer_count++;
            void'(q[m_owner].pop_front());
            if (bus.req_last[m_owner] || m_cnt == MAXB) begin
               m_own = 1'b0;
               m_cnt = 0;
               m_ptr = (m_owner + 1) % NREQ;
            end
         end
      end
   end

   // Cycle compare of every DUT output against the model.
   always @(negedge clock) begin
      if (cmp_en) begin
         check("req_ready", int'(bus.req_ready), m_own ? (1 << m_owner) : 0);
         check("busy", int'(busy), int'(m_own));
         if (m_own) check("owner", int'(owner), m_owner);
         check("vga_plot", int'(vga_plot), int'(e_plot));
         if (e_plot) begin
            check("vga_x", int'(vga_x), e_x);
            check("vga_y", int'(vga_y), e_y);
            check("vga_colour", int'(vga_colour), e_c);
         end
         if (vga_plot) plot_log.push_back('{int'(vga_x), int'(vga_y), int'(vga_colour), cyc});
      end
   end

   task automatic push(int r, int x, int y, int c, bit last, int gap);
      q[r].push_back('{x, y, c, last, gap});
   endtask

   task automatic drain(bit need_idle);
      bit done = 1'b0;
      for (int n = 0; n < 2000; n++) begin
         if (all_empty() && (!need_idle || !m_own)) begin
            done = 1'b1;
            break;
         end
         @(negedge clock);
      end
      if (!done) check("drain_timeout", 0, 1);
      repeat (3) @(negedge clock);
   endtask

   task automatic do_reset();
      @(negedge clock);
      resetn = 1'b0;
      @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);
   endtask

   task automatic clear_logs();
      grant_log.delete();
      plot_log.delete();
   endtask

   initial begin
      int base;
      bus.req_valid = '0; bus.req_last = '0;
      bus.req_x = '0; bus.req_y = '0; bus.req_colour = '0;
      for (int i = 0; i < NREQ; i++) push(i, 50 + i, 60, i, 1'b1, 0);

      // Reset held with every requester valid.
      repeat (2) @(negedge clock);
      cmp_en = 1'b1;
      repeat (4) @(negedge clock);
      clear_logs();
      resetn = 1'b1;
      @(negedge clock);
      check("first_ready_is_req0", int'(bus.req_ready), 1);
      drain(1'b1);
      check("reset_grants_n", grant_log.size(), 3);
      for (int k = 0; k < 3; k++) check("reset_grant_order", glog(k), k);

      // Single 4-pixel job from req1.
      clear_logs();
      for (int k = 0; k < 4; k++) push(1, 10 + k, 20, 5, k == 3, 0);
      drain(1'b1);
      check("single_plots", plot_log.size(), 4);
      for (int k = 0; k < plot_log.size() && k < 4; k++) begin
         check("single_x", plot_log[k].x, 10 + k);
         check("single_y", plot_log[k].y, 20);
         check("single_colour", plot_log[k].c, 5);
         check("single_back_to_back", plot_log[k].cyc, plot_log[0].cyc + k);
      end
      check("single_model_ptr", m_ptr, 2);

      // Round robin with 2-pixel jobs, colour tags the producer.
      do_reset();
      clear_logs();
      for (int j = 0; j < 2; j++) for (int k = 0; k < 2; k++) push(0, 30 + 2*j + k, 1, 0, k == 1, 0);
      for (int k = 0; k < 2; k++) push(1, 40 + k, 2, 1, k == 1, 0);
      for (int k = 0; k < 2; k++) push(2, 50 + k, 3, 2, k == 1, 0);
      drain(1'b1);
      check("rr_grants_n", grant_log.size(), 4);
      check("rr_grant0", glog(0), 0);
      check("rr_grant1", glog(1), 1);
      check("rr_grant2", glog(2), 2);
      check("rr_grant3", glog(3), 0);
      check("rr_plots", plot_log.size(), 8);
      for (int k = 0; k < plot_log.size() && k < 8; k++)
         check("rr_pixel_owner", plot_log[k].c, (k < 6) ? k / 2 : 0);

      // Burst limit: req0 never asserts last, req2 waiting.
      do_reset();
      clear_logs();
      for (int k = 0; k < 10; k++) push(0, 100 + k, 7, 3, 1'b0, 0);
      for (int k = 0; k < 2; k++) push(2, 150 + k, 8, 6, k == 1, 0);
      drain(1'b0);
      check("burst_grants_n", grant_log.size(), 4);
      check("burst_grant0", glog(0), 0);
      check("burst_grant1", glog(1), 2);
      check("burst_grant2", glog(2), 0);
      check("burst_plots", plot_log.size(), 12);
      for (int k = 0; k < plot_log.size() && k < 12; k++)
         check("burst_pixel_owner", plot_log[k].c, (k == 4 || k == 5) ? 6 : 3);
      check("burst_stall_busy", int'(busy), 1);

      // Clip then stall gap.
      do_reset();
      clear_logs();
      base = xfer_count;
      push(0, 320, 5, 1, 1'b0, 0);
      push(0, 319, 239, 2, 1'b1, 3);
      drain(1'b1);
      check("clip_accepted", xfer_count - base, 2);
      check("clip_plots", plot_log.size(), 1);
      if (plot_log.size() > 0) begin
         check("clip_x", plot_log[0].x, 319);
         check("clip_y", plot_log[0].y, 239);
      end

      // Reset in the middle of a req1 burst.
      clear_logs();
      for (int k = 0; k < 6; k++) push(1, 200 + k, 30, 7, k == 5, 0);
      for (int n = 0; n < 200 && plot_log.size() < 2; n++) @(negedge clock);
      check("midjob_started", int'(plot_log.size() >= 2), 1);
      resetn = 1'b0;
      @(negedge clock);
      check("midjob_plot_dropped", int'(vga_plot), 0);
      check("midjob_busy", int'(busy), 0);
      grant_log.delete();
      push(0, 5, 5, 1, 1'b1, 0);
      resetn = 1'b1;
      drain(1'b1);
      check("midjob_ptr_reset", glog(0), 0);

      // Randomized jobs with gaps and burst-limit crossings.
      for (int r = 0; r < 40; r++) begin
         for (int i = 0; i < NREQ; i++) begin
            if ($urandom_range(0, 2) != 0) begin
               int len = $urandom_range(1, 6);
               for (int k = 0; k < len; k++)
                  push(i, $urandom_range(0, 339), $urandom_range(0, 255), $urandom_range(0, 7),
                       k == len - 1, $urandom_range(0, 2));
            end
         end
         drain(1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
